mem_port_arbiter: RTL and testbench

//   Shares one single-port memory between the CPU instruction-fetch port and data port.

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_port_arbiter_wait_counter.sv | 38 +++
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  // Existing CPU bus widths (InstAddressBus / InstDataBus).
  localparam int unsigned INST_ADDR_BUS_W = 32;
  localparam int unsigned INST_DATA_BUS_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_PORT_IF = 1'b0,
    ARB_PORT_DM = 1'b1
  } arb_port_t;

  // Counter width able to hold WAIT_CYCLES-1 (at least one bit).
  function automatic int unsigned wait_cnt_w(input int unsigned wait_cycles);
    return (wait_cycles > 1) ? $clog2(wait_cycles) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// Memory wait-state counter: loads WAIT_CYCLES-1 on start, counts down,
// and flags done in the cycle the count reaches zero.
module mem_port_arbiter_wait_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  output logic o_done_c
);

  localparam int unsigned CNT_W = wait_cnt_w(WAIT_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  // Load on start, then count down until the final wait cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_cnt  <= CNT_W'(WAIT_CYCLES - 1);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign o_done_c = r_busy & (r_cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between the fetch (if) and data (dm)
// ports. Optional macro ARB_ROUND_ROBIN_EN: alternate grants under contention;
// without it the data port always wins.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = INST_ADDR_BUS_W,
  parameter int unsigned DATA_W      = INST_DATA_BUS_W,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_data_o,
  output logic                if_ack_o,
  input  logic                dm_req_i,
  input  logic                dm_we_i,
  input  logic [ADDR_W-1:0]   dm_addr_i,
  input  logic [DATA_W-1:0]   dm_wdata_i,
  input  logic [DATA_W/8-1:0] dm_sel_i,
  output logic [DATA_W-1:0]   dm_rdata_o,
  output logic                dm_ack_o,
  output logic                mem_ce_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_sel_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                stall_req_o
);

  arb_state_t r_state;
  arb_port_t  r_grant;
  logic       w_any_req;
  logic       w_grant_dm;
  logic       w_start;
  logic       w_done;

  assign w_any_req = if_req_i | dm_req_i;

`ifdef ARB_ROUND_ROBIN_EN
  arb_port_t r_last_grant;

  // Contention goes to the port not served last; a lone requester always wins.
  assign w_grant_dm = (if_req_i & dm_req_i) ? (r_last_grant == ARB_PORT_IF) : dm_req_i;

  // Remember the most recent grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= ARB_PORT_IF;
    end else if (w_start) begin
      r_last_grant <= w_grant_dm ? ARB_PORT_DM : ARB_PORT_IF;
    end
  end
`else
  // Data port wins contention to break the fetch/load structural hazard.
  assign w_grant_dm = dm_req_i;
`endif

  assign w_start = (r_state == ARB_IDLE) & w_any_req;

  mem_port_arbiter_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_counter (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start),
    .o_done_c (w_done)
  );

  // Arbitration FSM with registered memory controls, acks and read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_grant     <= ARB_PORT_IF;
      if_data_o   <= '0;
      if_ack_o    <= 1'b0;
      dm_rdata_o  <= '0;
      dm_ack_o    <= 1'b0;
      mem_ce_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_sel_o   <= '0;
    end else begin
      if_ack_o <= 1'b0;
      dm_ack_o <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_any_req) begin
            r_state  <= ARB_ACCESS;
            mem_ce_o <= 1'b1;
            if (w_grant_dm) begin
              r_grant     <= ARB_PORT_DM;
              mem_we_o    <= dm_we_i;
              mem_addr_o  <= dm_addr_i;
              mem_wdata_o <= dm_wdata_i;
              mem_sel_o   <= dm_sel_i;
            end else begin
              r_grant     <= ARB_PORT_IF;
              mem_we_o    <= 1'b0;
              mem_addr_o  <= if_addr_i;
              mem_wdata_o <= '0;
              mem_sel_o   <= '1;
            end
          end
        end
        ARB_ACCESS: begin
          if (w_done) begin
            r_state  <= ARB_RESP;
            mem_ce_o <= 1'b0;
            mem_we_o <= 1'b0;
            if (r_grant == ARB_PORT_DM) begin
              dm_ack_o <= 1'b1;
              if (!mem_we_o) begin
                dm_rdata_o <= mem_rdata_i;
              end
            end else begin
              if_ack_o  <= 1'b1;
              if_data_o <= mem_rdata_i;
            end
          end
        end
        ARB_RESP: begin
          r_state <= ARB_IDLE;
        end
        default: begin
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign stall_req_o = w_any_req & ~(if_ack_o | dm_ack_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with WAIT_CYCLES=2.
module tb_mem_port_arbiter;

  localparam int unsigned WAITC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_ack_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [3:0]  dm_sel_i;
  logic [31:0] dm_rdata_o;
  logic        dm_ack_o;
  logic        mem_ce_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_rdata_i;
  logic        stall_req_o;

  mem_port_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .WAIT_CYCLES (WAITC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_data_o   (if_data_o),
    .if_ack_o    (if_ack_o),
    .dm_req_i    (dm_req_i),
    .dm_we_i     (dm_we_i),
    .dm_addr_i   (dm_addr_i),
    .dm_wdata_i  (dm_wdata_i),
    .dm_sel_i    (dm_sel_i),
    .dm_rdata_o  (dm_rdata_o),
    .dm_ack_o    (dm_ack_o),
    .mem_ce_o    (mem_ce_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_sel_o   (mem_sel_o),
    .mem_rdata_i (mem_rdata_i),
    .stall_req_o (stall_req_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        if_q[$];
  exp_t        dm_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  int          cyc    = 0;
  logic [31:0] exp_dm_rdata = 32'h0;
  logic [31:0] mem [0:127];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    else n_pass++;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port memory: combinational read, byte-masked write.
  assign mem_rdata_i = mem_ce_o ? mem[mem_addr_o[8:2]] : 32'h0;
  always @(posedge clk) begin
    if (mem_ce_o && mem_we_o) begin
      for (int b = 0; b < 4; b++)
        if (mem_sel_o[b]) mem[mem_addr_o[8:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
    end
  end

  // Scoreboard: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (if_ack_o) begin
      if (if_q.size() == 0) chk("if_ack_unexpected", 64'(if_ack_o), 64'd0);
      else begin
        e = if_q.pop_front();
        chk("if_data", 64'(if_data_o), 64'(e.data));
        chk("if_ack_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (dm_ack_o) begin
      if (dm_q.size() == 0) chk("dm_ack_unexpected", 64'(dm_ack_o), 64'd0);
      else begin
        e = dm_q.pop_front();
        chk("dm_rdata", 64'(dm_rdata_o), 64'(e.data));
        chk("dm_ack_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Fetch access, called at a negedge; ack expected lat cycles later.
  task automatic if_access(input logic [31:0] addr, input logic [31:0] exp_data,
                           input int lat, input bit drop, input bit detail);
    bit got = 1'b0;
    if_req_i  = 1'b1;
    if_addr_i = addr;
    if_q.push_back('{exp_data, cyc + lat});
    if (detail) begin
      #1 chk("if_stall_req", 64'(stall_req_o), 64'd1);
    end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (detail) begin
        chk("if_ce", 64'(mem_ce_o), 64'(i < 2));
        chk("if_stall", 64'(stall_req_o), 64'(i != 2));
        if (i < 2) chk("if_mem_addr", 64'(mem_addr_o), 64'(addr));
        if (i < 2) chk("if_mem_we", 64'(mem_we_o), 64'd0);
      end
      if (drop && i == 0) if_req_i = 1'b0;
      if (if_ack_o) got = 1'b1;
    end
    chk("if_ack_seen", 64'(got), 64'd1);
    if_req_i = 1'b0;
  endtask

  // Data access, called at a negedge; ack expected lat cycles later.
  task automatic dm_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] sel, input logic [31:0] rd_exp,
                           input int lat, input bit detail);
    bit got = 1'b0;
    dm_req_i   = 1'b1;
    dm_we_i    = we;
    dm_addr_i  = addr;
    dm_wdata_i = wdata;
    dm_sel_i   = sel;
    if (!we) exp_dm_rdata = rd_exp;
    dm_q.push_back('{exp_dm_rdata, cyc + lat});
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (detail && i < 2) begin
        chk("dm_ce", 64'(mem_ce_o), 64'd1);
        chk("dm_mem_we", 64'(mem_we_o), 64'(we));
        chk("dm_mem_addr", 64'(mem_addr_o), 64'(addr));
        chk("dm_mem_sel", 64'(mem_sel_o), 64'(sel));
        if (we) chk("dm_mem_wdata", 64'(mem_wdata_o), 64'(wdata));
      end
      if (detail && i == 2) chk("dm_ce_off", 64'(mem_ce_o), 64'd0);
      if (dm_ack_o) got = 1'b1;
    end
    chk("dm_ack_seen", 64'(got), 64'd1);
    dm_req_i = 1'b0;
    dm_we_i  = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_ack"}, 64'(if_ack_o), 64'd0);
    chk({tag, "_dm_ack"}, 64'(dm_ack_o), 64'd0);
    chk({tag, "_mem_ce"}, 64'(mem_ce_o), 64'd0);
    chk({tag, "_mem_we"}, 64'(mem_we_o), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr_o), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata_o), 64'd0);
    chk({tag, "_mem_sel"}, 64'(mem_sel_o), 64'd0);
    chk({tag, "_if_data"}, 64'(if_data_o), 64'd0);
    chk({tag, "_dm_rdata"}, 64'(dm_rdata_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 128; k++) mem[k] = 32'h0;
    mem[1] = 32'h3401_1100;
    mem[2] = 32'h1234_5678;
    rst = 1'b1;
    if_req_i = 1'b0; if_addr_i = '0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0; dm_sel_i = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    chk("reset_stall", 64'(stall_req_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Reset asserted mid-ACCESS: access abandoned, no ack afterwards.
    if_req_i = 1'b1; if_addr_i = 32'h4;
    @(negedge clk);
    chk("rst_mid_ce", 64'(mem_ce_o), 64'd1);
    rst = 1'b1; if_req_i = 1'b0;
    @(negedge clk);
    chk_all_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_mid_if_data", 64'(if_data_o), 64'd0);

    // Single fetch read with full timing detail.
    if_access(32'h0000_0004, 32'h3401_1100, WAITC + 1, 1'b0, 1'b1);
    @(negedge clk);
    chk("if_data_hold", 64'(if_data_o), 64'h3401_1100);
    chk("if_ack_pulse", 64'(if_ack_o), 64'd0);

    // Data read, then a write that must leave dm_rdata_o unchanged, then readback.
    dm_access(1'b0, 32'h8, 32'h0, 4'hF, 32'h1234_5678, WAITC + 1, 1'b1);
    @(negedge clk);
    dm_access(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 32'h0, WAITC + 1, 1'b1);
    @(negedge clk);
    chk("if_data_untouched", 64'(if_data_o), 64'h3401_1100);
    dm_access(1'b0, 32'h100, 32'h0, 4'hF, 32'hDEAD_BEEF, WAITC + 1, 1'b0);
    @(negedge clk);

    // Contention: both ports request in the same cycle.
`ifdef ARB_ROUND_ROBIN_EN
    fork
      dm_access(1'b0, 32'h8, 32'h0, 4'hF, 32'h1234_5678, 2 * WAITC + 3, 1'b0);
      if_access(32'h4, 32'h3401_1100, WAITC + 1, 1'b0, 1'b0);
    join
    @(negedge clk);
    // Continuous dual requests: grants alternate between the ports.
    fork
      begin
        if_access(32'h4, 32'h3401_1100, WAITC + 1, 1'b0, 1'b0);
        if_access(32'h4, 32'h3401_1100, 2 * WAITC + 4, 1'b0, 1'b0);
      end
      begin
        dm_access(1'b0, 32'h8, 32'h0, 4'hF, 32'h1234_5678, 2 * WAITC + 3, 1'b0);
        dm_access(1'b0, 32'h100, 32'h0, 4'hF, 32'hDEAD_BEEF, 2 * WAITC + 4, 1'b0);
      end
    join
`else
    fork
      dm_access(1'b0, 32'h8, 32'h0, 4'hF, 32'h1234_5678, WAITC + 1, 1'b0);
      if_access(32'h4, 32'h3401_1100, 2 * WAITC + 3, 1'b0, 1'b0);
    join
`endif
    @(negedge clk);

    // Fetch request dropped one cycle after grant still completes with one ack.
    mem[3] = 32'hCAFE_0003;
    if_access(32'hC, 32'hCAFE_0003, WAITC + 1, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk("stall_idle", 64'(stall_req_o), 64'd0);
    chk("if_q_drained", 64'(if_q.size()), 64'd0);
    chk("dm_q_drained", 64'(dm_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
